jtag_reg_bank: RTL

- Parametrised successor to the fixed-count JTAG register wrappers.
- Holds NUMBER_OF_REGISTERS host-writable output registers. Serves read and write commands from the already-synchronised JTAG bridge command port on iMAIN_CLK.
- Adds behaviour the earlier wrappers lack:
  - per-register write and read strobes;
  - a valid/ready command/response handshake;
  - error reporting for bad addresses;
  - a control/status word.
- Sits between the JTAG bridge and user logic; one instance per debug register set.

---
 rtl/jtag_reg_bank_pkg.sv | 16 +
 rtl/jtag_reg_bank_word.sv | 51 +++++
 rtl/jtag_reg_bank.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/jtag_reg_bank_pkg.sv
// Shared types and constants for the JTAG register bank: FSM states,
// version tag and control/status bit positions.
package jtag_reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0]  VERSION             = 8'hA1;
  localparam int unsigned CTRL_RESET_BIT      = 0;
  localparam int unsigned CTRL_SNAP_BIT       = 1;
  localparam int unsigned STAT_SNAP_VALID_BIT = 16;

endpackage

// File: rtl/jtag_reg_bank_word.sv
// One host-writable register of the JTAG register bank: load, bulk reload
// to the reset value, and registered one-cycle write/read strobes.
module jtag_reg_bank_word
  import jtag_reg_bank_pkg::*;
#(
  parameter int unsigned               REGISTER_SIZE = 32,
  parameter logic [REGISTER_SIZE-1:0]  RESET_VALUE   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     reload,
  input  logic                     read,
  input  logic [REGISTER_SIZE-1:0] wdata,
  output logic [REGISTER_SIZE-1:0] data,
  output logic                     wr_strobe,
  output logic                     rd_strobe
);

  logic [REGISTER_SIZE-1:0] data_q, data_d;
  logic                     wr_strobe_q, wr_strobe_d;
  logic                     rd_strobe_q, rd_strobe_d;

  always_comb begin
    data_d = data_q;
    if (reload) begin
      data_d = RESET_VALUE;
    end else if (load) begin
      data_d = wdata;
    end
    wr_strobe_d = load || reload;
    rd_strobe_d = read;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= RESET_VALUE;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  assign data      = data_q;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;

endmodule

// File: rtl/jtag_reg_bank.sv
// JTAG register bank: IDLE/EXEC/RESP command FSM, address decode and
// control/status word. Optional snapshot buffer: JTAG_REG_BANK_SNAPSHOT_EN.
module jtag_reg_bank
  import jtag_reg_bank_pkg::*;
#(
  parameter int unsigned               REGISTER_SIZE       = 32,
  parameter int unsigned               NUMBER_OF_REGISTERS = 15,
  parameter logic [REGISTER_SIZE-1:0]  RESET_VALUE         = '0,
  localparam int unsigned              ADDR_WIDTH          = $clog2(NUMBER_OF_REGISTERS + 1)
) (
  input  logic                                         iMAIN_CLK,
  input  logic                                         iRESET,
  input  logic                                         iCMD_VALID,
  output logic                                         oCMD_READY,
  input  logic                                         iCMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]                        iCMD_ADDR,
  input  logic [REGISTER_SIZE-1:0]                     iCMD_WDATA,
  output logic                                         oRSP_VALID,
  input  logic                                         iRSP_READY,
  output logic [REGISTER_SIZE-1:0]                     oRSP_RDATA,
  output logic                                         oRSP_ERR,
  input  logic [NUMBER_OF_REGISTERS*REGISTER_SIZE-1:0] iDATA,
  output logic [NUMBER_OF_REGISTERS*REGISTER_SIZE-1:0] oDATA,
  output logic [NUMBER_OF_REGISTERS-1:0]               oWR_STROBE,
  output logic [NUMBER_OF_REGISTERS-1:0]               oRD_STROBE
);

  localparam int unsigned           NW        = NUMBER_OF_REGISTERS * REGISTER_SIZE;
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(NUMBER_OF_REGISTERS);
  localparam int unsigned           STAT_W    = (REGISTER_SIZE > 17) ? REGISTER_SIZE : 17;

  state_e                   state_q, state_d;
  logic                     write_q, write_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [REGISTER_SIZE-1:0] wdata_q, wdata_d;
  logic [REGISTER_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_err_q, rsp_err_d;

  logic                           exec;
  logic                           in_range;
  logic                           ctrl_hit;
  logic                           bad_addr;
  logic                           bulk_reload;
  logic [NUMBER_OF_REGISTERS-1:0] wr_sel;
  logic [NUMBER_OF_REGISTERS-1:0] rd_sel;
  logic [NW-1:0]                  rd_src;
  logic [REGISTER_SIZE-1:0]       rd_word;
  logic [STAT_W-1:0]              status_full;
  logic [REGISTER_SIZE-1:0]       status_word;
  logic                           snap_valid;

  assign exec        = (state_q == EXEC);
  assign in_range    = (addr_q < CTRL_ADDR);
  assign ctrl_hit    = (addr_q == CTRL_ADDR);
  assign bad_addr    = (addr_q > CTRL_ADDR);
  assign bulk_reload = exec && write_q && ctrl_hit && wdata_q[CTRL_RESET_BIT];

`ifdef JTAG_REG_BANK_SNAPSHOT_EN
  logic [NW-1:0] snap_q, snap_d;
  logic          snap_valid_q, snap_valid_d;

  always_comb begin
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    if (exec && write_q && ctrl_hit && wdata_q[CTRL_SNAP_BIT]) begin
      snap_d       = iDATA;
      snap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge iMAIN_CLK or posedge iRESET) begin
    if (iRESET) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign rd_src     = snap_q;
  assign snap_valid = snap_valid_q;
`else
  assign rd_src     = iDATA;
  assign snap_valid = 1'b0;
`endif

  always_comb begin
    status_full                      = '0;
    status_full[7:0]                 = 8'(NUMBER_OF_REGISTERS);
    status_full[15:8]                = VERSION;
    status_full[STAT_SNAP_VALID_BIT] = snap_valid;
  end

  assign status_word = status_full[REGISTER_SIZE-1:0];

  always_comb begin
    wr_sel  = '0;
    rd_sel  = '0;
    rd_word = '0;
    for (int unsigned i = 0; i < NUMBER_OF_REGISTERS; i++) begin
      if (addr_q == ADDR_WIDTH'(i)) begin
        wr_sel[i] = exec && write_q;
        rd_sel[i] = exec && !write_q;
        rd_word   = rd_src[i*REGISTER_SIZE +: REGISTER_SIZE];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (iCMD_VALID) begin
          state_d = EXEC;
          write_d = iCMD_WRITE;
          addr_d  = iCMD_ADDR;
          wdata_d = iCMD_WDATA;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_err_d   = bad_addr;
        rsp_rdata_d = '0;
        if (!write_q && in_range) begin
          rsp_rdata_d = rd_word;
        end else if (!write_q && ctrl_hit) begin
          rsp_rdata_d = status_word;
        end
      end
      RESP: begin
        if (iRSP_READY) begin
          state_d     = IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iMAIN_CLK or posedge iRESET) begin
    if (iRESET) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Ready is gated by reset so the bridge never sees an accept while held in reset.
  assign oCMD_READY = (state_q == IDLE) && !iRESET;
  assign oRSP_VALID = (state_q == RESP);
  assign oRSP_RDATA = rsp_rdata_q;
  assign oRSP_ERR   = rsp_err_q;

  for (genvar g = 0; g < NUMBER_OF_REGISTERS; g++) begin : g_word
    jtag_reg_bank_word #(
      .REGISTER_SIZE (REGISTER_SIZE),
      .RESET_VALUE   (RESET_VALUE)
    ) u_word (
      .clk       (iMAIN_CLK),
      .rst       (iRESET),
      .load      (wr_sel[g]),
      .reload    (bulk_reload),
      .read      (rd_sel[g]),
      .wdata     (wdata_q),
      .data      (oDATA[g*REGISTER_SIZE +: REGISTER_SIZE]),
      .wr_strobe (oWR_STROBE[g]),
      .rd_strobe (oRD_STROBE[g])
    );
  end

endmodule
